// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer.
//   PC_W     - width of PC and Jump_Address
//   RESET_PC - PC value loaded while Clear is low
//   CNT_W    - width of the saturating accepted-fetch counter
//   pc_state_e - sequencer states; code 2'b11 is unused and recovers to RUN
package pc_pkg;

    localparam int              PC_W     = 8;
    localparam logic [PC_W-1:0] RESET_PC = 8'h00;
    localparam int              CNT_W    = 16;

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        BR_WAIT = 2'b01,
        HALTED  = 2'b10
    } pc_state_e;

endpackage

// File: rtl/pc_sequencer_sat_counter.sv
// Saturating up-counter: counts enabled cycles and sticks at all-ones.
//   clk_i   - clock, rising edge
//   rst_ni  - asynchronous active-low clear to zero
//   en_i    - count this cycle
//   count_o - current count
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (en_i && (count_q != {W{1'b1}})) begin
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter stage feeding the jump-target adder and instruction fetch.
// On a taken branch the PC is held for one cycle (BR_WAIT) so the adder's
// registered target settles, then Jump_Address is loaded.
//   Clk          - clock, rising edge
//   Clear        - asynchronous active-low reset
//   Fetch_Ready  - instruction memory accepts the current PC
//   Stall        - downstream hazard, hold PC
//   Branch_Taken - taken branch resolved for the instruction at PC
//   Halt         - halt request, sticky until Clear
//   Jump_Address - registered branch target from the jump adder
//   PC           - current program counter
//   Fetch_Req    - fetch request (combinational)
//   Flush        - one-cycle pulse in the first BR_WAIT cycle
//   Halted       - sequencer is halted
//   Fetch_Count  - saturating count of accepted sequential fetches
module pc_sequencer #(
    parameter int                PC_W     = pc_pkg::PC_W,
    parameter logic [PC_W-1:0]   RESET_PC = pc_pkg::RESET_PC,
    parameter int                CNT_W    = pc_pkg::CNT_W
) (
    input  logic             Clk,
    input  logic             Clear,
    input  logic             Fetch_Ready,
    input  logic             Stall,
    input  logic             Branch_Taken,
    input  logic             Halt,
    input  logic [PC_W-1:0]  Jump_Address,
    output logic [PC_W-1:0]  PC,
    output logic             Fetch_Req,
    output logic             Flush,
    output logic             Halted,
    output logic [CNT_W-1:0] Fetch_Count
);

    import pc_pkg::*;

    pc_state_e        state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic             flush_q, flush_d;
    logic             halted_q;
    logic             advance;

    assign Fetch_Req = (state_q == RUN) && !Stall;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        flush_d = 1'b0;
        advance = 1'b0;
        case (state_q)
            RUN: begin
                if (Halt) begin
                    state_d = HALTED;
                end else if (Branch_Taken) begin
                    // Branch beats Stall: PC must stay put so the adder sees it.
                    state_d = BR_WAIT;
                    flush_d = 1'b1;
                end else if (Fetch_Req && Fetch_Ready) begin
                    pc_d    = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
                    advance = 1'b1;
                end
            end
            BR_WAIT: begin
                if (Halt) begin
                    state_d = HALTED;
                end else if (!Stall) begin
                    // PC unchanged since the branch, so the target is still valid.
                    pc_d    = Jump_Address;
                    state_d = RUN;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Clear) begin
        if (!Clear) begin
            state_q  <= RUN;
            pc_q     <= RESET_PC;
            flush_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            flush_q  <= flush_d;
            halted_q <= (state_d == HALTED);
        end
    end

    sat_counter #(.W(CNT_W)) u_fetch_cnt (
        .clk_i   (Clk),
        .rst_ni  (Clear),
        .en_i    (advance),
        .count_o (Fetch_Count)
    );

    assign PC     = pc_q;
    assign Flush  = flush_q;
    assign Halted = halted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    logic        Clk = 1'b0;
    logic        Clear, Fetch_Ready, Stall, Branch_Taken, Halt;
    logic [7:0]  Jump_Address, offset;
    logic [7:0]  PC;
    logic        Fetch_Req, Flush, Halted;
    logic [15:0] Fetch_Count;

    // Narrow-counter build for the saturation check.
    logic        Clear4, Fetch_Ready4;
    logic [7:0]  PC4, jaddr4;
    logic        Fetch_Req4, Flush4, Halted4;
    logic [3:0]  Fetch_Count4;

    int ncmp = 0;
    int nfail = 0;

    always #5 Clk = ~Clk;

    // Jump adder model: registers PC + 1 + offset each cycle.
    always @(posedge Clk) Jump_Address <= PC + 8'd1 + offset;
    always @(posedge Clk) jaddr4 <= PC4 + 8'd1;

    pc_sequencer dut (
        .Clk(Clk), .Clear(Clear), .Fetch_Ready(Fetch_Ready), .Stall(Stall),
        .Branch_Taken(Branch_Taken), .Halt(Halt), .Jump_Address(Jump_Address),
        .PC(PC), .Fetch_Req(Fetch_Req), .Flush(Flush), .Halted(Halted),
        .Fetch_Count(Fetch_Count)
    );

    pc_sequencer #(.CNT_W(4)) dut4 (
        .Clk(Clk), .Clear(Clear4), .Fetch_Ready(Fetch_Ready4), .Stall(1'b0),
        .Branch_Taken(1'b0), .Halt(1'b0), .Jump_Address(jaddr4),
        .PC(PC4), .Fetch_Req(Fetch_Req4), .Flush(Flush4), .Halted(Halted4),
        .Fetch_Count(Fetch_Count4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Clear = 1'b0; Fetch_Ready = 1'b1; Stall = 1'b0; Branch_Taken = 1'b0;
        Halt = 1'b0; offset = 8'h00;
        Clear4 = 1'b0; Fetch_Ready4 = 1'b1;
        #2;
        // Reset state
        chk("rst_pc",     32'(PC), 32'h00);
        chk("rst_flush",  32'(Flush), 32'h0);
        chk("rst_halted", 32'(Halted), 32'h0);
        chk("rst_cnt",    32'(Fetch_Count), 32'h0);
        chk("rst_freq",   32'(Fetch_Req), 32'h1);
        @(negedge Clk);
        Clear = 1'b1;

        // 1. sequential advance
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("t1_pc", 32'(PC), 32'(i));
        end
        chk("t1_cnt",   32'(Fetch_Count), 32'd4);
        chk("t1_flush", 32'(Flush), 32'h0);

        // 2. branch at 0x10, offset 5 -> 0x16
        repeat (12) step();
        chk("t2_pc_pre", 32'(PC), 32'h10);
        offset = 8'h05; Branch_Taken = 1'b1;
        step();
        chk("t2_bw_pc",    32'(PC), 32'h10);
        chk("t2_bw_flush", 32'(Flush), 32'h1);
        chk("t2_bw_freq",  32'(Fetch_Req), 32'h0);
        Branch_Taken = 1'b0;
        step();
        chk("t2_tgt_pc",    32'(PC), 32'h16);
        chk("t2_tgt_flush", 32'(Flush), 32'h0);
        chk("t2_tgt_freq",  32'(Fetch_Req), 32'h1);
        step();
        chk("t2_seq_pc",  32'(PC), 32'h17);
        chk("t2_seq_cnt", 32'(Fetch_Count), 32'd17);

        // 3. branch at 0x03 offset -6 with Stall over two BR_WAIT cycles
        Clear = 1'b0; #1;
        chk("t3_clr_pc",  32'(PC), 32'h00);
        chk("t3_clr_cnt", 32'(Fetch_Count), 32'h0);
        Clear = 1'b1;
        repeat (3) step();
        chk("t3_pc_pre", 32'(PC), 32'h03);
        offset = 8'hFA; Branch_Taken = 1'b1; Stall = 1'b1;
        step();
        chk("t3_c1_pc",    32'(PC), 32'h03);
        chk("t3_c1_flush", 32'(Flush), 32'h1);
        Branch_Taken = 1'b0;
        step();
        chk("t3_c2_pc",    32'(PC), 32'h03);
        chk("t3_c2_flush", 32'(Flush), 32'h0);
        step();
        chk("t3_c3_pc",    32'(PC), 32'h03);
        chk("t3_c3_flush", 32'(Flush), 32'h0);
        chk("t3_c3_freq",  32'(Fetch_Req), 32'h0);
        Stall = 1'b0;
        step();
        chk("t3_tgt_pc", 32'(PC), 32'hFE);
        chk("t3_cnt",    32'(Fetch_Count), 32'd3);

        // 4. wrap FF -> 00, then Fetch_Ready low holds
        offset = 8'h00;
        step();
        chk("t4_pc_ff", 32'(PC), 32'hFF);
        step();
        chk("t4_pc_wrap", 32'(PC), 32'h00);
        chk("t4_cnt",     32'(Fetch_Count), 32'd5);
        Fetch_Ready = 1'b0;
        step(); step();
        chk("t4_hold_pc",  32'(PC), 32'h00);
        chk("t4_hold_cnt", 32'(Fetch_Count), 32'd5);
        Fetch_Ready = 1'b1;

        // 5. Halt beats Branch_Taken; sticky until Clear
        step(); step();
        chk("t5_pc_pre", 32'(PC), 32'h02);
        Halt = 1'b1; Branch_Taken = 1'b1;
        step();
        chk("t5_halted", 32'(Halted), 32'h1);
        chk("t5_flush",  32'(Flush), 32'h0);
        chk("t5_pc",     32'(PC), 32'h02);
        chk("t5_freq",   32'(Fetch_Req), 32'h0);
        Halt = 1'b0; Branch_Taken = 1'b0;
        repeat (3) step();
        chk("t5_stay_pc",     32'(PC), 32'h02);
        chk("t5_stay_halted", 32'(Halted), 32'h1);
        chk("t5_stay_cnt",    32'(Fetch_Count), 32'd7);
        Clear = 1'b0; #1;
        chk("t5_clr_pc",     32'(PC), 32'h00);
        chk("t5_clr_halted", 32'(Halted), 32'h0);
        Clear = 1'b1;

        // Halt during BR_WAIT discards the branch
        step();
        offset = 8'h10; Branch_Taken = 1'b1;
        step();
        chk("bwh_pc_bw", 32'(PC), 32'h01);
        Branch_Taken = 1'b0; Halt = 1'b1;
        step();
        chk("bwh_halted", 32'(Halted), 32'h1);
        chk("bwh_pc",     32'(PC), 32'h01);
        Halt = 1'b0;
        step();
        chk("bwh_pc2", 32'(PC), 32'h01);

        // Clear during BR_WAIT loses the pending branch
        Clear = 1'b0; #1; Clear = 1'b1;
        step();
        Branch_Taken = 1'b1;
        step();
        chk("cbw_flush", 32'(Flush), 32'h1);
        Branch_Taken = 1'b0;
        Clear = 1'b0; #1;
        chk("cbw_pc",    32'(PC), 32'h00);
        chk("cbw_flush0", 32'(Flush), 32'h0);
        Clear = 1'b1;
        step();
        chk("cbw_run_pc", 32'(PC), 32'h01);

        // 6. 4-bit counter saturates at F
        Clear4 = 1'b1;
        repeat (14) step();
        chk("t6_cnt14", 32'(Fetch_Count4), 32'hE);
        step();
        chk("t6_cnt15", 32'(Fetch_Count4), 32'hF);
        repeat (5) step();
        chk("t6_cnt20", 32'(Fetch_Count4), 32'hF);
        chk("t6_pc20",  32'(PC4), 32'h14);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
